// File: rtl/sum_serial.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock and rips the carry
// between chunks, so a WIDTH-bit result appears NCH = WIDTH/CHUNK cycles after start.
module sum_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   sum_ch;
    logic             cin_msb;
    int unsigned      base;

    // Current chunk slice and its CHUNK-bit add with the running carry.
    always_comb begin
        base    = 32'(k_q) * CHUNK;
        a_ch    = a_q[base +: CHUNK];
        b_ch    = b_q[base +: CHUNK];
        sum_ch  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk MSB recovered from the MSB sum bit and its operands.
        cin_msb = sum_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        k_d     = k_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is A + ~B + ~borrow_in.
                    state_d = RUN;
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? ~c_in : c_in;
                    k_d     = '0;
                end
            end
            RUN: begin
                res_d[base +: CHUNK] = sum_ch[CHUNK-1:0];
                carry_d              = sum_ch[CHUNK];
                k_d                  = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    k_d     = '0;
                    s_d     = res_d;
                    c_out_d = sum_ch[CHUNK];
                    ovf_d   = cin_msb ^ sum_ch[CHUNK];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign S     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule
